// File: rtl/mem_pkg.sv
// mem_pkg: shared state enum and lane rotate/merge helpers for swap_mem_dp
package mem_pkg;
  localparam int MAX_W = 256;
  localparam int MAX_L = 32;
  localparam int IDX_W = $clog2(MAX_W);
  localparam int LIDX_W = $clog2(MAX_L);
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  function automatic logic [MAX_W-1:0] rot_lanes(input logic [MAX_W-1:0] data, input int lane_w, input int data_w);
    logic [MAX_W-1:0] r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < data_w) r[IDX_W'((i + lane_w) % data_w)] = data[i];
    return r;
  endfunction
  function automatic logic [MAX_W-1:0] merge_lanes(input logic [MAX_W-1:0] old, input logic [MAX_W-1:0] nw,
                                                   input logic [MAX_L-1:0] be, input int lane_w);
    logic [MAX_W-1:0] r = '0;
    for (int i = 0; i < MAX_W; i++)
      r[i] = be[LIDX_W'(i / lane_w)] ? nw[i] : old[i];
    return r;
  endfunction
endpackage

// File: rtl/swap_mem_rdpipe.sv
// swap_mem_rdpipe: LAT-deep read valid/data pipeline; ports clk, rst, in_valid/in_data -> out_valid/out_data
module swap_mem_rdpipe #(
  parameter int W = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         v [LAT];
  logic [W-1:0] d [LAT];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v[0] <= 1'b0;
      d[0] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
    end
  for (genvar g = 1; g < LAT; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v[g] <= 1'b0;
        d[g] <= '0;
      end else begin
        v[g] <= v[g-1];
        if (v[g-1]) d[g] <= d[g-1];
      end
  end
  assign out_valid = v[LAT-1];
  assign out_data = d[LAT-1];
endmodule

// File: rtl/swap_mem_dp.sv
// swap_mem_dp: simple dual-port memory with lane rotation, byte enables and clear sweep; ports clk, rst, clr_req, busy, wr_*, rd_*
module swap_mem_dp import mem_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int LANES = 2,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 2**ADDR_W,
  parameter int SWAP_BASE = DEPTH/2,
  parameter int RD_LAT = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LANES-1:0]  wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int LANE_W = DATA_W / LANES;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              last, swap, wr_ok, rd_ok, wr_fire, rd_fire, hit;
  logic [LANES-1:0]  wr_lanes;
  logic [DATA_W-1:0] wr_word, wr_old, wr_merged, rd_word;
  assign busy = state == ST_CLEAR;
  assign last = cnt == ADDR_W'(DEPTH - 1);
  assign wr_ok = 32'(wr_addr) < DEPTH;
  assign rd_ok = 32'(rd_addr) < DEPTH;
  assign swap = 32'(wr_addr) >= SWAP_BASE;
  assign wr_fire = wr_en && !busy && wr_ok;
  assign rd_fire = rd_en && !busy;
  assign hit = wr_fire && rd_addr == wr_addr;
  // rotating the enables alongside the data keeps each input lane gated by its own be bit
  assign wr_word = swap ? DATA_W'(rot_lanes(MAX_W'(wr_data), LANE_W, DATA_W)) : wr_data;
  assign wr_lanes = swap ? LANES'(rot_lanes(MAX_W'(wr_be), 1, LANES)) : wr_be;
  assign wr_old = wr_ok ? mem[wr_addr] : '0;
  assign wr_merged = DATA_W'(merge_lanes(MAX_W'(wr_old), MAX_W'(wr_word), MAX_L'(wr_lanes), LANE_W));
  assign rd_word = !rd_ok ? '0 : (WRITE_FIRST != 0 && hit) ? wr_merged : mem[rd_addr];
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= '0;
    else if (wr_fire) mem[wr_addr] <= wr_merged;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = busy ? (last ? ST_IDLE : ST_CLEAR) : (clr_req ? ST_CLEAR : ST_IDLE);
    cnt_n = busy && !last ? cnt + 1'b1 : '0;
  end
  swap_mem_rdpipe #(.W(DATA_W), .LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(rd_fire),
    .in_data(rd_word),
    .out_valid(rd_valid),
    .out_data(rd_data)
  );
endmodule

// File: tb/tb_swap_mem_dp.sv
// tb_swap_mem_dp: randomized + directed check of two swap_mem_dp configurations against a behavioural model
module tb_swap_mem_dp;
  localparam int NCYC = 4096;
  logic        clk = 0, rst = 1, clr_req = 0, wr_en = 0, rd_en = 0;
  logic [3:0]  wr_addr = 0, rd_addr = 0;
  logic [15:0] wr_data = 0;
  logic [1:0]  wr_be = 0;
  logic        busy0, busy1, v0, v1;
  logic [15:0] d0, d1;
  int          total = 0, bad = 0, cyc = 0, clr_left = 16;
  logic [15:0] mm [16];
  bit          ev [2][NCYC];
  logic [15:0] ed [2][NCYC];
  logic [15:0] last_d [2];
  always #5 clk = ~clk;
  swap_mem_dp u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0)
  );
  swap_mem_dp #(.RD_LAT(2), .WRITE_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  // stored word: each enabled input lane j goes to lane j, or lane (j+1)%2 above the swap base
  function automatic logic [15:0] store_word(input logic [3:0] a, input logic [15:0] old,
                                             input logic [15:0] d, input logic [1:0] be);
    logic [15:0] w = old;
    for (int j = 0; j < 2; j++)
      if (be[j]) begin
        int dst = (a >= 8) ? (j + 1) % 2 : j;
        w[dst*8 +: 8] = d[j*8 +: 8];
      end
    return w;
  endfunction
  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      if (ev[k][cyc]) last_d[k] = ed[k][cyc];
      chk(k ? "valid1" : "valid0", k ? v1 : v0, ev[k][cyc]);
      chk(k ? "data1" : "data0", k ? d1 : d0, last_d[k]);
      chk(k ? "busy1" : "busy0", k ? busy1 : busy0, rst || clr_left > 0);
    end
  endtask
  task automatic tick();
    if (cyc + 3 >= NCYC) begin
      $display("FAIL budget cyc=%0d exceeded limit=%0d", cyc, NCYC);
      $fatal(1);
    end
    if (!rst) begin
      if (clr_left > 0) clr_left--;
      else begin
        logic [15:0] nw = store_word(wr_addr, mm[wr_addr], wr_data, wr_be);
        if (rd_en)
          for (int k = 0; k < 2; k++) begin
            ev[k][cyc+k+1] = 1;
            ed[k][cyc+k+1] = (k == 1 && wr_en && wr_addr == rd_addr) ? nw : mm[rd_addr];
          end
        if (wr_en) mm[wr_addr] = nw;
        if (clr_req) begin
          foreach (mm[i]) mm[i] = 0;
          clr_left = 16;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask
  task automatic op(input bit we, input int wa, input int wd, input int be,
                    input bit re, input int ra, input bit cr);
    wr_en = we; wr_addr = 4'(wa); wr_data = 16'(wd); wr_be = 2'(be);
    rd_en = re; rd_addr = 4'(ra); clr_req = cr;
    tick();
  endtask
  task automatic idle(input int n);
    repeat (n) op(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset_mid();
    #3 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k ? "rst_valid1" : "rst_valid0", k ? v1 : v0, 0);
      chk(k ? "rst_data1" : "rst_data0", k ? d1 : d0, 0);
      chk(k ? "rst_busy1" : "rst_busy0", k ? busy1 : busy0, 1);
      last_d[k] = 0;
      for (int c = cyc + 1; c < NCYC; c++) ev[k][c] = 0;
    end
    foreach (mm[i]) mm[i] = 0;
    clr_left = 16;
  endtask
  initial begin
    foreach (mm[i]) mm[i] = 0;
    last_d[0] = 0;
    last_d[1] = 0;
    idle(2);
    rst = 0;
    idle(16);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, a, 0);
    idle(2);
    op(1, 3, 'hABCD, 3, 0, 0, 0);
    op(1, 12, 'hABCD, 3, 0, 0, 0);
    op(0, 0, 0, 0, 1, 3, 0);
    op(0, 0, 0, 0, 1, 12, 0);
    idle(2);
    op(1, 12, 'h1234, 1, 0, 0, 0);
    op(1, 2, 'h5678, 2, 0, 0, 0);
    op(0, 0, 0, 0, 1, 12, 0);
    op(0, 0, 0, 0, 1, 2, 0);
    idle(2);
    op(1, 5, 'h1111, 3, 0, 0, 0);
    op(1, 5, 'h2222, 3, 1, 5, 0);
    op(0, 0, 0, 0, 1, 5, 0);
    idle(2);
    op(0, 0, 0, 0, 1, 3, 1);
    idle(2);
    op(1, 4, 'hFFFF, 3, 1, 4, 1);
    repeat (14) op(1, 7, $urandom, 3, 1, 7, 0);
    op(0, 0, 0, 0, 1, 3, 0);
    op(0, 0, 0, 0, 1, 4, 0);
    op(0, 0, 0, 0, 1, 7, 0);
    idle(2);
    op(1, 8, 'h0F0F, 3, 0, 0, 0);
    op(1, 9, 'hA5A5, 3, 0, 0, 0);
    op(0, 0, 0, 0, 1, 8, 0);
    op(0, 0, 0, 0, 1, 9, 0);
    reset_mid();
    op(0, 0, 0, 0, 1, 10, 0);
    op(0, 0, 0, 0, 1, 11, 0);
    rst = 0;
    idle(16);
    op(0, 0, 0, 0, 1, 8, 0);
    repeat (600)
      op($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 3),
         $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 63) == 0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
